// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle: stage register numbers and control bits in,
// stall/flush/forwarding controls and performance counters out.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             resultsrc_e, regwrite_m, regwrite_w, pcsrc_e, clr_cnt;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output resultsrc_e, regwrite_m, regwrite_w, pcsrc_e, clr_cnt,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  resultsrc_e, regwrite_m, regwrite_w, pcsrc_e, clr_cnt,
        output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage pipeline: operand forwarding, multi-cycle load-use stall
// and branch-flush sequencing, and saturating stall/flush event counters.
//
// state | meaning
// RUN   | no sequence in progress; react to redirect or load-use this cycle
// STALL | holding F/D and bubbling E for the remaining load-use cycles
// FLUSH | clearing F/D and D/E for the remaining redirect cycles
module hazard_unit #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hz
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [3:0]       STALL_LOAD = 4'(STALL_CYCLES - 1);
    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    logic [3:0]       cnt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             lu, do_stall, do_flush;
    logic [1:0]       fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic [4:0] rd_w, input logic wr_m,
                                           input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        else                                         return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(hz.rs1_e, hz.rd_m, hz.rd_w, hz.regwrite_m, hz.regwrite_w);
    assign fwd_b = fwd_sel(hz.rs2_e, hz.rd_m, hz.rd_w, hz.regwrite_m, hz.regwrite_w);
    assign lu    = hz.resultsrc_e && hz.rd_e != 5'd0 &&
                   (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);

    // A redirect always wins over a stall; load-use is ignored while flushing.
    always_comb begin
        do_stall = 1'b0;
        do_flush = 1'b0;
        case (state)
            RUN: begin
                if (hz.pcsrc_e) do_flush = 1'b1;
                else if (lu)    do_stall = 1'b1;
            end
            STALL: begin
                if (hz.pcsrc_e) do_flush = 1'b1;
                else            do_stall = 1'b1;
            end
            FLUSH:   do_flush = 1'b1;
            default: ;
        endcase
    end

    assign hz.stall_f   = rst_n & do_stall;
    assign hz.stall_d   = rst_n & do_stall;
    assign hz.flush_d   = rst_n & do_flush;
    assign hz.flush_e   = rst_n & (do_stall | do_flush);
    assign hz.fwd_a_e   = rst_n ? fwd_a : 2'b00;
    assign hz.fwd_b_e   = rst_n ? fwd_b : 2'b00;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.pcsrc_e) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= FLUSH;
                            cnt   <= FLUSH_LOAD;
                        end
                    end else if (lu && STALL_CYCLES > 1) begin
                        state <= STALL;
                        cnt   <= STALL_LOAD;
                    end
                end
                STALL: begin
                    if (hz.pcsrc_e) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= FLUSH;
                            cnt   <= FLUSH_LOAD;
                        end else begin
                            state <= RUN;
                            cnt   <= 4'd0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= RUN;
                    end
                end
                FLUSH: begin
                    if (hz.pcsrc_e) begin
                        if (FLUSH_CYCLES > 1) cnt <= FLUSH_LOAD;
                        else                  state <= RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hz.clr_cnt) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (do_stall && stall_cnt_q != CNT_MAX)   stall_cnt_q <= stall_cnt_q + 1'b1;
            if (hz.pcsrc_e && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: forwarding vector table, directed multi-cycle
// sequences and a randomized run against a pending-cycle reference model.
module tb_hazard_unit;
    localparam int SC = 3;
    localparam int FC = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk, rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    hazard_if #(.CNT_W(CW)) hz ();
    hazard_unit #(.STALL_CYCLES(SC), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] rs1_e, rs2_e, rd_m, rd_w;
        logic       wm, ww;
        logic [1:0] exp_a, exp_b;
    } fwd_vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        hz.rs1_d = 0; hz.rs2_d = 0; hz.rs1_e = 0; hz.rs2_e = 0;
        hz.rd_e = 0; hz.rd_m = 0; hz.rd_w = 0;
        hz.resultsrc_e = 0; hz.regwrite_m = 0; hz.regwrite_w = 0;
        hz.pcsrc_e = 0; hz.clr_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ctrl();
        return {28'd0, hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e};
    endfunction

    task automatic clear_cnts();
        hz.clr_cnt = 1;
        tick();
        hz.clr_cnt = 0;
    endtask

    function automatic int ref_fwd(input int rs, input int rdm, input int rdw,
                                   input bit wm, input bit ww);
        if (wm && rdm != 0 && rdm == rs) return 2;
        if (ww && rdw != 0 && rdw == rs) return 1;
        return 0;
    endfunction

    fwd_vec_t vecs[7];

    initial begin
        int pend_flush, pend_stall, m_stall, m_flush, exp_ctrl;
        bit lu;

        vecs[0] = '{5'd5,  5'd3,  5'd5, 5'd5,  1'b1, 1'b1, 2'b10, 2'b00};
        vecs[1] = '{5'd5,  5'd3,  5'd5, 5'd5,  1'b0, 1'b1, 2'b01, 2'b00};
        vecs[2] = '{5'd0,  5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 2'b00, 2'b00};
        vecs[3] = '{5'd4,  5'd9,  5'd9, 5'd4,  1'b1, 1'b1, 2'b01, 2'b10};
        vecs[4] = '{5'd6,  5'd6,  5'd6, 5'd6,  1'b0, 1'b0, 2'b00, 2'b00};
        vecs[5] = '{5'd31, 5'd31, 5'd1, 5'd31, 1'b1, 1'b1, 2'b01, 2'b01};
        vecs[6] = '{5'd2,  5'd2,  5'd2, 5'd7,  1'b1, 1'b0, 2'b10, 2'b10};

        // reset state, with forwarding inputs active to see the forced 00
        rst_n = 0;
        idle();
        hz.rs1_e = 5; hz.rd_m = 5; hz.regwrite_m = 1;
        #2;
        chk("reset_ctrl", ctrl(), 0);
        chk("reset_fwd_a", int'(hz.fwd_a_e), 0);
        chk("reset_stall_cnt", int'(hz.stall_cnt), 0);
        chk("reset_flush_cnt", int'(hz.flush_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle();
        tick();

        foreach (vecs[i]) begin
            hz.rs1_e = vecs[i].rs1_e; hz.rs2_e = vecs[i].rs2_e;
            hz.rd_m = vecs[i].rd_m;   hz.rd_w = vecs[i].rd_w;
            hz.regwrite_m = vecs[i].wm; hz.regwrite_w = vecs[i].ww;
            #1;
            chk($sformatf("fwd_a_vec%0d", i), int'(hz.fwd_a_e), int'(vecs[i].exp_a));
            chk($sformatf("fwd_b_vec%0d", i), int'(hz.fwd_b_e), int'(vecs[i].exp_b));
        end
        idle();
        tick();

        // load-use: 3 stall cycles from a single-cycle hazard
        clear_cnts();
        hz.resultsrc_e = 1; hz.rd_e = 7; hz.rs2_d = 7;
        #1 chk("lu_cyc1", ctrl(), 4'b1101);
        tick(); idle();
        #1 chk("lu_cyc2", ctrl(), 4'b1101);
        tick();
        chk("lu_cyc3", ctrl(), 4'b1101);
        tick();
        chk("lu_done", ctrl(), 0);
        chk("lu_stall_cnt", int'(hz.stall_cnt), 3);

        // redirect: 2 flush cycles
        clear_cnts();
        hz.pcsrc_e = 1;
        #1 chk("br_cyc1", ctrl(), 4'b0011);
        tick(); hz.pcsrc_e = 0;
        #1 chk("br_cyc2", ctrl(), 4'b0011);
        tick();
        chk("br_done", ctrl(), 0);
        chk("br_flush_cnt", int'(hz.flush_cnt), 1);

        // load-use and redirect together: flush only
        clear_cnts();
        hz.pcsrc_e = 1; hz.resultsrc_e = 1; hz.rd_e = 3; hz.rs1_d = 3;
        #1 chk("both_cyc1", ctrl(), 4'b0011);
        tick(); idle();
        #1 chk("both_cyc2", ctrl(), 4'b0011);
        tick();
        chk("both_done", ctrl(), 0);
        chk("both_stall_cnt", int'(hz.stall_cnt), 0);
        chk("both_flush_cnt", int'(hz.flush_cnt), 1);

        // redirect in the second stall cycle
        clear_cnts();
        hz.resultsrc_e = 1; hz.rd_e = 9; hz.rs1_d = 9;
        #1 chk("sbr_cyc1", ctrl(), 4'b1101);
        tick(); idle(); hz.pcsrc_e = 1;
        #1 chk("sbr_cyc2", ctrl(), 4'b0011);
        tick(); hz.pcsrc_e = 0;
        #1 chk("sbr_cyc3", ctrl(), 4'b0011);
        tick();
        chk("sbr_done", ctrl(), 0);
        chk("sbr_stall_cnt", int'(hz.stall_cnt), 1);
        chk("sbr_flush_cnt", int'(hz.flush_cnt), 1);

        // saturation, then clear racing a stall
        clear_cnts();
        hz.resultsrc_e = 1; hz.rd_e = 4; hz.rs2_d = 4;
        repeat (20) tick();
        chk("sat_stall_cnt", int'(hz.stall_cnt), CMAX);
        hz.clr_cnt = 1;
        #1 chk("clr_ctrl", ctrl(), 4'b1101);
        tick(); idle();
        #1 chk("clr_stall_cnt", int'(hz.stall_cnt), 0);
        repeat (3) tick();
        chk("clr_drained", ctrl(), 0);

        // async reset in the middle of a stall
        hz.resultsrc_e = 1; hz.rd_e = 7; hz.rs1_d = 7;
        #1 chk("ar_cyc1", ctrl(), 4'b1101);
        tick(); idle();
        hz.rs1_e = 5; hz.rd_m = 5; hz.regwrite_m = 1;
        #1 chk("ar_cyc2", ctrl(), 4'b1101);
        chk("ar_fwd_pre", int'(hz.fwd_a_e), 2);
        #2 rst_n = 0;
        #1 chk("ar_ctrl_now", ctrl(), 0);
        chk("ar_fwd_now", int'(hz.fwd_a_e), 0);
        chk("ar_stall_cnt_now", int'(hz.stall_cnt), 0);
        #2 rst_n = 1;
        idle();
        tick();
        chk("ar_after_ctrl", ctrl(), 0);
        chk("ar_after_stall_cnt", int'(hz.stall_cnt), 0);
        chk("ar_after_flush_cnt", int'(hz.flush_cnt), 0);

        // randomized run against pending-cycle model
        pend_flush = 0; pend_stall = 0; m_stall = 0; m_flush = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            hz.rs1_d = 5'($urandom_range(0, 3)); hz.rs2_d = 5'($urandom_range(0, 3));
            hz.rs1_e = 5'($urandom_range(0, 3)); hz.rs2_e = 5'($urandom_range(0, 3));
            hz.rd_e = 5'($urandom_range(0, 3));  hz.rd_m = 5'($urandom_range(0, 3));
            hz.rd_w = 5'($urandom_range(0, 3));
            hz.resultsrc_e = ($urandom_range(0, 2) == 0);
            hz.regwrite_m = 1'($urandom); hz.regwrite_w = 1'($urandom);
            hz.pcsrc_e = ($urandom_range(0, 7) == 0);
            hz.clr_cnt = ($urandom_range(0, 31) == 0);
            #1;
            lu = hz.resultsrc_e && hz.rd_e != 0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
            if (hz.pcsrc_e) begin
                exp_ctrl = 4'b0011; pend_flush = FC - 1; pend_stall = 0;
            end else if (pend_flush > 0) begin
                exp_ctrl = 4'b0011; pend_flush--;
            end else if (pend_stall > 0) begin
                exp_ctrl = 4'b1101; pend_stall--;
            end else if (lu) begin
                exp_ctrl = 4'b1101; pend_stall = SC - 1;
            end else begin
                exp_ctrl = 0;
            end
            chk("rnd_ctrl", ctrl(), exp_ctrl);
            chk("rnd_fwd_a", int'(hz.fwd_a_e), ref_fwd(hz.rs1_e, hz.rd_m, hz.rd_w,
                                                       hz.regwrite_m, hz.regwrite_w));
            chk("rnd_fwd_b", int'(hz.fwd_b_e), ref_fwd(hz.rs2_e, hz.rd_m, hz.rd_w,
                                                       hz.regwrite_m, hz.regwrite_w));
            chk("rnd_stall_cnt", int'(hz.stall_cnt), m_stall);
            chk("rnd_flush_cnt", int'(hz.flush_cnt), m_flush);
            if (hz.clr_cnt) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (exp_ctrl == 4'b1101 && m_stall < CMAX) m_stall++;
                if (hz.pcsrc_e && m_flush < CMAX) m_flush++;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer/controller side of the 5-stage pipeline register bank: reads stage register numbers and control bits from D/E/M/W, and drives back stall, flush and operand-forwarding selects.
- Adds multi-cycle behaviour for configurable load-use latency and branch-flush depth.
- Includes saturating stall/flush performance counters.
- Sits beside the pipeline registers in the CPU top level.

Parameters:
- STALL_CYCLES, 1, cycles F/D are held per load-use hazard (1..15)
- FLUSH_CYCLES, 1, cycles D/E are flushed per taken jump/branch (1..15)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs1_d  in  5  rs1 of instruction in Decode
- rs2_d  in  5  rs2 of instruction in Decode
- rs1_e  in  5  rs1 of instruction in Execute
- rs2_e  in  5  rs2 of instruction in Execute
- rd_e  in  5  destination in Execute
- rd_m  in  5  destination in Memory
- rd_w  in  5  destination in Writeback
- resultsrc_e  in  1  Execute instruction is a load
- regwrite_m  in  1  Memory-stage RegWrite
- regwrite_w  in  1  Writeback-stage RegWrite
- pcsrc_e  in  1  taken jump/branch resolved in Execute
- clr_cnt  in  1  synchronous clear of both counters
- stall_f  out  1  hold PC register
- stall_d  out  1  hold F/D register
- flush_d  out  1  clear F/D register
- flush_e  out  1  clear D/E register (bubble)
- fwd_a_e  out  2  ALU operand A select: 00 regfile, 01 W result, 10 M ALUout
- fwd_b_e  out  2  ALU operand B select, same encoding
- stall_cnt  out  CNT_W  cycles with stall_d=1
- flush_cnt  out  CNT_W  accepted redirect events

Behaviour:
- Reset is asynchronous and active-low:
  - rst_n=0: state=RUN, down-counter=0, stall_cnt=flush_cnt=0.
  - While rst_n=0, stall_f, stall_d, flush_d and flush_e are forced 0, and fwd_a_e/fwd_b_e are forced 00.
- Forwarding (combinational, every state):
  - fwd_a_e=10 if regwrite_m and rd_m!=0 and rd_m==rs1_e.
  - Otherwise fwd_a_e=01 if regwrite_w and rd_w!=0 and rd_w==rs1_e.
  - Otherwise fwd_a_e=00. M has priority over W. fwd_b_e is identical using rs2_e.
- Load-use detect (combinational): lu = resultsrc_e and rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d).
- FSM states: RUN, STALL, FLUSH. Down-counter is 4 bits.
- RUN:
  - pcsrc_e=1 (priority over lu): flush_d=flush_e=1 this cycle and flush_cnt increments. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
  - Else lu=1: stall_f=stall_d=flush_e=1 this cycle. If STALL_CYCLES>1, go to STALL with counter=STALL_CYCLES-1.
  - Else all stall/flush outputs are 0.
- STALL:
  - stall_f=stall_d=flush_e=1 each cycle; counter decrements; return to RUN after the cycle in which counter==1.
  - pcsrc_e=1 in STALL: flush wins. Outputs flush_d=flush_e=1 with stalls 0, flush_cnt increments, and the FSM takes the RUN redirect path (FLUSH or RUN).
- FLUSH:
  - flush_d=flush_e=1, stalls 0; counter decrements; return to RUN after the cycle in which counter==1.
  - pcsrc_e=1 in FLUSH: flush_cnt increments and counter reloads to FLUSH_CYCLES-1. If FLUSH_CYCLES==1, this is a no-op (already returning to RUN).
- Defaults (1/1): the FSM never leaves RUN; behaviour is the classic single-cycle hazard unit.
- Counters:
  - stall_cnt increments on every cycle stall_d=1; flush_cnt increments on every accepted pcsrc_e.
  - Both saturate at all-ones with no wrap.
  - clr_cnt=1 zeroes both next edge and takes priority over an increment in the same cycle.
- Reset mid-STALL/FLUSH returns immediately to RUN with outputs deasserted. No residual stall after rst_n rises.

Test Plan:
- Forwarding priority: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwd_a_e=10. Set regwrite_m=0 -> fwd_a_e=01. Set rd_m=rd_w=0 with both regwrites=1 and rs1_e=0 -> fwd_a_e=00.
- Load-use, STALL_CYCLES=3: resultsrc_e=1, rd_e=7, rs2_d=7 for one cycle -> stall_f=stall_d=flush_e=1 for exactly 3 cycles, then 0; stall_cnt=3.
- Redirect, FLUSH_CYCLES=2: pcsrc_e pulse -> flush_d=flush_e=1 for 2 cycles, stalls 0; flush_cnt=1.
- Simultaneous events: lu=1 and pcsrc_e=1 in the same cycle -> flush only, stall_f=0, stall_cnt unchanged. pcsrc_e during cycle 2 of STALL -> stalls drop that cycle and flush sequence runs.
- Counter saturation and clear: CNT_W=4, 20 stall cycles -> stall_cnt=15. clr_cnt together with a stall -> stall_cnt=0 next cycle.
- Async reset: assert rst_n=0 mid-STALL (no clock edge) -> all control outputs 0 immediately; after release with inputs idle, state RUN and counters 0.
